// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO state for the E stage.
// Multiply-class ops (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) stay busy for MUL_CYCLES,
// and divides (DIV/DIVU) for DIV_CYCLES. The captured operands are committed to
// HI/LO on the final edge. MTHI/MTLO write in one cycle. flush cancels an
// in-flight op and drops a same-cycle start.
// Ports:
//   clk, reset (async, active-low)
//   start, flush, MDOp[3:0], D1/D2[WIDTH-1:0]  - request from decode/execute
//   busy, done                                - registered status
//   result[WIDTH-1:0]                         - combinational MFHI/MFLO read
module mdu_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       MDOp,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] d1_q, d2_q;
  logic [WIDTH-1:0] hi, lo;

  logic             is_mul, is_div;
  logic             op_signed;
  logic [W2-1:0]    a_ext, b_ext, prod, hilo_next;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, divisor, uq, ur, quo, rem;

  // Classify the incoming op.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (MDOp)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
      OP_DIV, OP_DIVU:                                         is_div = 1'b1;
      default: ;
    endcase
  end

  // Result of the captured op, which is applied to HI/LO on the commit edge.
  always_comb begin
    op_signed = (op_q == OP_MULT) || (op_q == OP_MADD) ||
                (op_q == OP_MSUB) || (op_q == OP_DIV);
    a_ext = op_signed ? {{WIDTH{d1_q[WIDTH-1]}}, d1_q} : {{WIDTH{1'b0}}, d1_q};
    b_ext = op_signed ? {{WIDTH{d2_q[WIDTH-1]}}, d2_q} : {{WIDTH{1'b0}}, d2_q};
    prod  = a_ext * b_ext;

    // Signed divide works on magnitudes. The most negative dividend negates
    // to itself, which is its correct unsigned magnitude, so MIN / -1 wraps to MIN rem 0.
    neg_a   = op_signed && d1_q[WIDTH-1];
    neg_b   = op_signed && d2_q[WIDTH-1];
    mag_a   = neg_a ? -d1_q : d1_q;
    mag_b   = neg_b ? -d2_q : d2_q;
    divisor = (d2_q == '0) ? WIDTH'(1) : mag_b;
    uq      = mag_a / divisor;
    ur      = mag_a % divisor;
    quo     = (neg_a ^ neg_b) ? -uq : uq;
    rem     = neg_a ? -ur : ur;

    hilo_next = {hi, lo};
    case (op_q)
      OP_MULT, OP_MULTU: hilo_next = prod;
      OP_MADD, OP_MADDU: hilo_next = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: hilo_next = {hi, lo} - prod;
      OP_DIV, OP_DIVU:   hilo_next = (d2_q == '0) ? {d1_q, {WIDTH{1'b1}}} : {rem, quo};
      default: ;
    endcase
  end

  // Control FSM together with the HI/LO and operand registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (is_mul || is_div) begin
              op_q  <= MDOp;
              d1_q  <= D1;
              d2_q  <= D2;
              cnt   <= is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end else if (MDOp == OP_MTHI) begin
              hi <= D1;
            end else if (MDOp == OP_MTLO) begin
              lo <= D1;
            end
          end
        end
        RUN: begin
          // flush beats a coinciding commit
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_W'(1)) begin
            {hi, lo} <= hilo_next;
            cnt      <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MFHI/MFLO read path.
  always_comb begin
    result = '0;
    case (MDOp)
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter. It uses a 32-bit default instance and an
// 8-bit single-cycle-multiply instance. Expected HI/LO values come from a
// behavioural model that is pushed to a scoreboard when an op is issued and
// popped when done pulses.
module tb_mdu_iter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, flush;
  logic [3:0]  op;
  logic [31:0] d1, d2;
  logic        busy, done;
  logic [31:0] result;

  logic        s8_start, s8_flush;
  logic [3:0]  s8_op;
  logic [7:0]  s8_d1, s8_d2;
  logic        s8_busy, s8_done;
  logic [7:0]  s8_result;

  mdu_iter dut (
    .clk(clk), .reset(rst_n), .start(start), .flush(flush), .MDOp(op),
    .D1(d1), .D2(d2), .busy(busy), .done(done), .result(result)
  );

  mdu_iter #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(10)) dut8 (
    .clk(clk), .reset(rst_n), .start(s8_start), .flush(s8_flush), .MDOp(s8_op),
    .D1(s8_d1), .D2(s8_d2), .busy(s8_busy), .done(s8_done), .result(s8_result)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] hi_m, lo_m;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  // Reference model: updates the architectural HI/LO and queues the expected value.
  task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc, ps, pu;
    int sa, sd;
    exp_t e;
    acc = {hi_m, lo_m};
    ps  = 64'(longint'($signed(a)) * longint'($signed(b)));
    pu  = {32'd0, a} * {32'd0, b};
    case (o)
      4'd1:  {hi_m, lo_m} = ps;
      4'd2:  {hi_m, lo_m} = pu;
      4'd9:  {hi_m, lo_m} = acc + ps;
      4'd10: {hi_m, lo_m} = acc + pu;
      4'd11: {hi_m, lo_m} = acc - ps;
      4'd12: {hi_m, lo_m} = acc - pu;
      4'd3: begin
        if (b == 32'd0) begin
          hi_m = a; lo_m = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi_m = 32'd0; lo_m = 32'h8000_0000;
        end else begin
          sa = a; sd = b;
          lo_m = sa / sd;
          hi_m = sa % sd;
        end
      end
      4'd4: begin
        if (b == 32'd0) begin
          hi_m = a; lo_m = 32'hFFFF_FFFF;
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
      end
      default: ;
    endcase
    e.hi = hi_m;
    e.lo = lo_m;
    sb.push_back(e);
  endtask

  // Read HI and LO through the MFHI/MFLO path. Call this just after a negedge.
  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    op = 4'd5; #1 h = result;
    op = 4'd6; #1 l = result;
    op = 4'd0;
  endtask

  // Issue a multi-cycle op. poke>0 drives an MTHI during that busy cycle.
  // flush_at>0 asserts flush during that busy cycle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke, input int flush_at);
    int n, exp_cyc;
    logic [31:0] h, l;
    exp_t e;
    exp_cyc = (o == 4'd3 || o == 4'd4) ? 10 : 5;
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b;
    if (flush_at == 0) model_op(o, a, b);
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL op%0d done_during_busy: got %b expected 0", o, done);
      end
      start = (n == poke);
      op    = (n == poke) ? 4'd7 : 4'd0;
      d1    = (n == poke) ? 32'hDEAD_BEEF : a;
      flush = (n == flush_at);
      @(negedge clk);
    end
    start = 1'b0; op = 4'd0; flush = 1'b0;
    if (flush_at != 0) begin
      checks++;
      if (n !== flush_at) begin
        errors++; $display("FAIL op%0d flush_busy_len: got %0d expected %0d", o, n, flush_at);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL op%0d flush_done: got %b expected 0", o, done);
      end
      read_hilo(h, l);
      checks++;
      if (h !== hi_m || l !== lo_m) begin
        errors++; $display("FAIL op%0d flush_hilo: got %h_%h expected %h_%h", o, h, l, hi_m, lo_m);
      end
    end else begin
      checks++;
      if (n !== exp_cyc) begin
        errors++; $display("FAIL op%0d busy_len: got %0d expected %0d", o, n, exp_cyc);
      end
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL op%0d done_pulse: got %b expected 1", o, done);
      end
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL op%0d scoreboard_empty: got 0 expected 1", o);
      end else begin
        e = sb.pop_front();
        read_hilo(h, l);
        checks++;
        if (h !== e.hi || l !== e.lo) begin
          errors++; $display("FAIL op%0d a=%h b=%h hilo: got %h_%h expected %h_%h",
                             o, a, b, h, l, e.hi, e.lo);
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL op%0d done_width: got %b expected 0", o, done);
      end
    end
  endtask

  // Move a value into HI or LO. This is single-cycle, with no busy and no done.
  task automatic mt(input logic [3:0] o, input logic [31:0] a);
    logic [31:0] h, l;
    @(negedge clk);
    start = 1'b1; op = o; d1 = a;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    if (o == 4'd7) hi_m = a; else lo_m = a;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mt%0d status: got busy=%b done=%b expected 0 0", o, busy, done);
    end
    read_hilo(h, l);
    checks++;
    if (h !== hi_m || l !== lo_m) begin
      errors++; $display("FAIL mt%0d hilo: got %h_%h expected %h_%h", o, h, l, hi_m, lo_m);
    end
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    rst_n = 1'b0;
    start = 1'b0; flush = 1'b0; op = 4'd0; d1 = '0; d2 = '0;
    s8_start = 1'b0; s8_flush = 1'b0; s8_op = 4'd0; s8_d1 = '0; s8_d2 = '0;
    hi_m = '0; lo_m = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s8_busy !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b done=%b busy8=%b expected 0 0 0", busy, done, s8_busy);
    end
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL reset_hilo: got %h_%h expected 0_0", h, l);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL reset_release_busy: got %b expected 0", busy);
      end
    end
  endtask

  task automatic test_mult;
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 0, 0);
  endtask

  task automatic test_div;
    logic [31:0] h, l;
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    read_hilo(h, l);
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg7_by_2: got %h_%h expected ffffffff_fffffffd", h, l);
    end
    run_op(4'd3, 32'h0000_1234, 32'd0, 0, 0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", h, l);
    end
    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(4'd4, 32'h0000_5678, 32'd0, 0, 0);
  endtask

  task automatic test_mac;
    logic [31:0] h, l;
    mt(4'd7, 32'd0);
    mt(4'd8, 32'hFFFF_FFFF);
    run_op(4'd10, 32'd1, 32'd1, 0, 0);
    read_hilo(h, l);
    checks++;
    if (h !== 32'd1 || l !== 32'd0) begin
      errors++; $display("FAIL maddu_carry: got %h_%h expected 00000001_00000000", h, l);
    end
    run_op(4'd11, 32'd1, 32'd1, 0, 0);
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL msub_borrow: got %h_%h expected 00000000_ffffffff", h, l);
    end
    run_op(4'd9, 32'hFFFF_FFFD, 32'd5, 0, 0);
    run_op(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
  endtask

  task automatic test_flush;
    logic [31:0] h, l;
    run_op(4'd1, 32'd3, 32'd4, 0, 3);
    run_op(4'd3, 32'd100, 32'd7, 0, 10);
    // A flush in IDLE drops a same-cycle MTHI.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 4'd7; d1 = 32'h0000_ABCD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 4'd0;
    read_hilo(h, l);
    checks++;
    if (h !== hi_m || l !== lo_m) begin
      errors++; $display("FAIL flush_drops_mt: got %h_%h expected %h_%h", h, l, hi_m, lo_m);
    end
    run_op(4'd2, 32'd6, 32'd7, 0, 0);
  endtask

  task automatic test_ignore_start;
    run_op(4'd9, 32'd2, 32'd3, 2, 0);
    run_op(4'd4, 32'd1000, 32'd9, 4, 0);
  endtask

  task automatic test_reset_midrun;
    logic [31:0] h, l;
    @(negedge clk);
    start = 1'b1; op = 4'd1; d1 = 32'd5; d2 = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_midrun_busy: got %b expected 0", busy);
    end
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL reset_midrun_hilo: got %h_%h expected 0_0", h, l);
    end
  endtask

  task automatic test_random;
    logic [3:0] ops[8];
    logic [3:0] o;
    logic [31:0] a, b;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
    for (int i = 0; i < 16; i++) begin
      o = ops[$urandom_range(7)];
      a = $urandom();
      b = ($urandom_range(5) == 0) ? 32'd0 : 32'($urandom());
      run_op(o, a, b, 0, 0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] h, l;
    @(negedge clk);
    s8_start = 1'b1; s8_op = 4'd1; s8_d1 = 8'h80; s8_d2 = 8'h80;
    @(negedge clk);
    s8_start = 1'b0; s8_op = 4'd0;
    checks++;
    if (s8_busy !== 1'b1 || s8_done !== 1'b0) begin
      errors++; $display("FAIL w8_busy1: got busy=%b done=%b expected 1 0", s8_busy, s8_done);
    end
    @(negedge clk);
    checks++;
    if (s8_busy !== 1'b0 || s8_done !== 1'b1) begin
      errors++; $display("FAIL w8_done: got busy=%b done=%b expected 0 1", s8_busy, s8_done);
    end
    s8_op = 4'd5; #1 h = s8_result;
    s8_op = 4'd6; #1 l = s8_result;
    checks++;
    if (h !== 8'h40 || l !== 8'h00) begin
      errors++; $display("FAIL w8_mult: got %h_%h expected 40_00", h, l);
    end
    // A new start is issued in the cycle where done is high.
    s8_start = 1'b1; s8_op = 4'd2; s8_d1 = 8'hFF; s8_d2 = 8'hFF;
    @(negedge clk);
    s8_start = 1'b0; s8_op = 4'd0;
    checks++;
    if (s8_busy !== 1'b1) begin
      errors++; $display("FAIL w8_b2b_accept: got busy=%b expected 1", s8_busy);
    end
    @(negedge clk);
    checks++;
    if (s8_done !== 1'b1) begin
      errors++; $display("FAIL w8_b2b_done: got %b expected 1", s8_done);
    end
    s8_op = 4'd5; #1 h = s8_result;
    s8_op = 4'd6; #1 l = s8_result;
    s8_op = 4'd0;
    checks++;
    if (h !== 8'hFE || l !== 8'h01) begin
      errors++; $display("FAIL w8_multu: got %h_%h expected fe_01", h, l);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mac();
    test_flush();
    test_ignore_start();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multi-cycle multiply/divide unit with HI/LO state, the successor to the fixed 32-bit execute-stage MD unit. Adds configurable operand width and per-class latency, multiply-accumulate/subtract ops, defined divide-by-zero and overflow results, and a flush input that cancels an in-flight operation on exception. Sits in the E stage beside the ALU. The hazard unit stalls MD-class instructions in D while `start | busy` is high.

## Interface
- `WIDTH`, 32, operand/HI/LO width in bits (≥ 8)
- `MUL_CYCLES`, 5, busy cycles for multiply and multiply-accumulate ops (≥ 1)
- `DIV_CYCLES`, 10, busy cycles for divide ops (≥ 1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  qualifies a write-class `MDOp` this cycle
- `flush`  in  1  cancel in-flight op and suppress this cycle's start
- `MDOp`  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU, 13–15 none
- `D1`  in  WIDTH  rs operand (dividend / multiplicand / MT source)
- `D2`  in  WIDTH  rt operand (divisor / multiplier)
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse: HI/LO just committed by a multi-cycle op
- `result`  out  WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational)

## Operation
- State: HI, LO, IDLE/RUN state flag, down-counter, captured op, and captured D1/D2.
- Reset (reset=0, async): HI=0, LO=0, state IDLE, counter 0, busy=0, done=0.
- IDLE, start=1, flush=0, op ∈ {1–4, 9–12}:
  - capture D1, D2, and op
  - load counter with MUL_CYCLES or DIV_CYCLES
  - enter RUN
- IDLE, start=1, flush=0, MTHI/MTLO: HI (or LO) ← D1 at the edge. No RUN, no busy, no done.
- RUN: decrement counter each edge. At the edge where it reaches 0:
  - commit HI/LO
  - return to IDLE
  - pulse `done`
- `start` while in RUN: ignored, including MTHI/MTLO.
- `start` with op 0, 5, 6, or 13–15: no state change.
- MULT/MULTU: {HI,LO} ← 2·WIDTH-bit signed/unsigned product.
- MADD(U)/MSUB(U): {HI,LO} ← {HI,LO} ± product, modulo 2^(2·WIDTH). Uses HI/LO at commit time, which equal the start-time values because nothing writes them during RUN.
- DIV: LO ← quotient truncated toward zero; HI ← remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): LO ← all ones, HI ← D1.
- DIV with D1 = −2^(WIDTH−1) and D2 = −1: LO ← −2^(WIDTH−1), HI ← 0.
- flush=1: at the next edge return to IDLE, counter ← 0, HI/LO unchanged, no done. Any start or MT in the same cycle is dropped. Flush in IDLE is a no-op.
- `result` reflects current registered HI/LO. During RUN it shows the pre-op value; the pipeline never issues MF while busy.

## Timing
- Start sampled at edge k (op with latency N): busy=1 during cycles k+1 … k+N.
- HI/LO committed at edge k+N. done=1 and busy=0 in cycle k+N+1's preceding interval, i.e. the cycle after edge k+N.
- A new start is accepted in the same cycle done is high, since the unit is IDLE.
- MTHI/MTLO: write visible on `result` (MFHI/MFLO) the cycle after the edge.
- `busy` and `done` are registered outputs. `result` is combinational from HI/LO and MDOp.
- Reset asserted mid-RUN: immediate abort to reset values. The op is lost.
- flush and the commit edge coincide (counter = 1 with flush=1): flush wins, no commit, no done.

## Test plan
- Reset, then MFHI/MFLO → result 0, busy 0. Deassert reset mid-cycle: no glitch on busy.
- Defaults, MULT D1=0xFFFFFFFF (−1), D2=2 → busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE; done one cycle. Repeat with MULTU → HI=1, LO=0xFFFFFFFE.
- DIV D1=−7, D2=2 → after 10 busy cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIV by 0 with D1=0x1234 → LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU D1=1, D2=1 → HI=1, LO=0. Then MSUB D1=1, D2=1 → HI=0, LO=0xFFFFFFFF.
- MULT started; flush in 3rd busy cycle → busy 0 next cycle, HI/LO keep prior values, no done. Second start issued during busy → ignored, busy length unchanged.
- WIDTH=8, MUL_CYCLES=1: MULT 0x80 × 0x80 → busy 1 cycle, HI=0x40, LO=0x00. Back-to-back start on the done cycle is accepted.
